axis_rr_arbiter: RTL

//  Packet-level round-robin arbiter that merges NUM_SRC AXI-Stream sources into one AXI-Stream

---
 rtl/axis_rr_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-level round-robin AXI-Stream merge with source id tagging
// A grant is held from arbitration until the granted source's tlast beat handshakes.
module axis_rr_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = $clog2(NUM_SRC)
) (
    input  logic                          axis_clk,
    input  logic                          axis_rst_n,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    input  logic [NUM_SRC-1:0]            src_en,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    output logic                          busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_SRC-1:0]    req;
    logic                  pick_found;
    logic [ID_WIDTH-1:0]   pick;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    // Walk offsets from the highest down so the smallest offset from rr_ptr is kept last.
    always_comb begin
        req        = s_axis_tvalid & src_en;
        pick_found = 1'b0;
        pick       = rr_ptr_q;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            int k;
            k = int'(rr_ptr_q) + i;
            if (k >= NUM_SRC) begin
                k = k - NUM_SRC;
            end
            for (int j = 0; j < NUM_SRC; j++) begin
                if (j == k && req[j]) begin
                    pick_found = 1'b1;
                    pick       = ID_WIDTH'(j);
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tid    = grant_q;
        s_axis_tready = '0;
        busy          = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                m_axis_tvalid = sel_valid;
                m_axis_tdata  = sel_data;
                m_axis_tlast  = sel_last;
                busy          = 1'b1;
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (grant_q == ID_WIDTH'(i)) begin
                        s_axis_tready[i] = m_axis_tready;
                    end
                end
                // Returning to IDLE here is what forces the single bubble between packets.
                if (sel_valid && m_axis_tready && sel_last) begin
                    rr_ptr_d = (grant_q == ID_WIDTH'(NUM_SRC - 1)) ? '0 : grant_q + ID_WIDTH'(1);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
